// File: rtl/pipe_pkg.sv
// pipe_pkg: shared slot type, forward-select encodings and tag-width helper for the hazard controller
package pipe_pkg;
  localparam int RW_MAX = 8;
  localparam int AGE_W = 2;
  localparam int FWD_RF = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB = 2;
  typedef struct packed {
    logic valid;
    logic [RW_MAX-1:0] rd;
    logic we;
    logic is_load;
    logic [AGE_W-1:0] age;
  } slot_t;
  function automatic int rw_of(input int nreg);
    return nreg <= 2 ? 1 : $clog2(nreg);
  endfunction
  function automatic slot_t advance(input slot_t s);
    slot_t r = s;
    r.age = s.age + AGE_W'(1);
    return r;
  endfunction
endpackage

// File: rtl/hz_slot_chain.sv
// hz_slot_chain: shadow pipeline of destination tags; slot 0 is EX, slot k sits k stages after EX
module hz_slot_chain import pipe_pkg::*; #(
  parameter int NFWD = 2,
  parameter int RW = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic [NFWD:0] en,
  input  logic flush,
  input  slot_t id_slot,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic id_use_rs1,
  input  logic id_use_rs2,
  output slot_t [NFWD:0] slots,
  output logic [RW-1:0] ex_rs1,
  output logic [RW-1:0] ex_rs2,
  output logic ex_use_rs1,
  output logic ex_use_rs2
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slots <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_use_rs1 <= 1'b0;
      ex_use_rs2 <= 1'b0;
    end else begin
      if (flush) begin
        slots[0] <= '0;
        ex_use_rs1 <= 1'b0;
        ex_use_rs2 <= 1'b0;
      end else if (en[0]) begin
        slots[0] <= id_slot;
        ex_rs1 <= id_rs1;
        ex_rs2 <= id_rs2;
        ex_use_rs1 <= id_use_rs1;
        ex_use_rs2 <= id_use_rs2;
      end
      for (int k = 1; k <= NFWD; k++)
        if (en[k]) slots[k] <= advance(slots[k-1]);
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stage enables, flushes, load-use interlock and operand forwarding for a 5-stage pipeline
// Define HAZARD_PERF_EN to add saturating stall/flush/freeze performance counters.
module pipe_hazard_ctrl import pipe_pkg::*; #(
  parameter int NREG = 32,
  parameter int NFWD = 2,
  parameter int LD_GAP = 1,
  localparam int RW = rw_of(NREG),
  localparam int FW = $clog2(NFWD + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic id_use_rs1,
  input  logic id_use_rs2,
  input  logic [RW-1:0] id_rd,
  input  logic id_rd_we,
  input  logic id_is_load,
  input  logic ex_redirect,
  input  logic mem_busy,
  output logic pc_en,
  output logic if_id_en,
  output logic id_ex_en,
  output logic ex_me_en,
  output logic me_wb_en,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_ld_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_freeze,
`endif
  output logic stall_ld
);
  slot_t [NFWD:0] slots;
  slot_t id_slot;
  logic [NFWD:0] slot_en;
  logic [RW-1:0] ex_rs1, ex_rs2;
  logic ex_use_rs1, ex_use_rs2, ld_hit;

  function automatic logic hit(input slot_t s, input logic [RW-1:0] rs, input logic use_rs);
    return use_rs && rs != '0 && s.valid && s.we && s.rd == RW_MAX'(rs);
  endfunction

  assign id_slot = '{valid: id_valid, rd: RW_MAX'(id_rd), we: id_rd_we, is_load: id_is_load, age: '0};

  always_comb begin
    slot_en = '0;
    for (int k = 0; k <= NFWD; k++)
      slot_en[k] = k == FWD_RF ? id_ex_en : k < FWD_WB ? ex_me_en : me_wb_en;
  end

  hz_slot_chain #(.NFWD(NFWD), .RW(RW)) u_chain (
    .clk(clk),
    .rst(rst),
    .en(slot_en),
    .flush(id_ex_flush),
    .id_slot(id_slot),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .slots(slots),
    .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2),
    .ex_use_rs1(ex_use_rs1),
    .ex_use_rs2(ex_use_rs2)
  );

  // A load still younger than LD_GAP stages has no data yet, so its consumer must wait in ID.
  always_comb begin
    ld_hit = 1'b0;
    for (int j = 0; j <= NFWD; j++)
      if (slots[j].is_load && int'(slots[j].age) < LD_GAP &&
          (hit(slots[j], id_rs1, id_use_rs1) || hit(slots[j], id_rs2, id_use_rs2)))
        ld_hit = id_valid;
  end

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    fwd_a = FW'(FWD_RF);
    fwd_b = FW'(FWD_RF);
    for (int k = NFWD; k >= 1; k--)
      if (!rst && slots[0].valid && (!slots[k].is_load || k > LD_GAP)) begin
        if (hit(slots[k], ex_rs1, ex_use_rs1)) fwd_a = FW'(k);
        if (hit(slots[k], ex_rs2, ex_use_rs2)) fwd_b = FW'(k);
      end
  end

  always_comb begin
    {pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en} = 5'b11111;
    {if_id_flush, id_ex_flush, stall_ld} = 3'b000;
    if (!rst) begin
      if (mem_busy) {pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en} = 5'b00000;
      else if (ex_redirect) {if_id_flush, id_ex_flush} = 2'b11;
      else if (ld_hit) {pc_en, if_id_en, id_ex_flush, stall_ld} = 4'b0011;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_ld_stall <= '0;
      perf_flush <= '0;
      perf_freeze <= '0;
    end else begin
      if (stall_ld && !(&perf_ld_stall)) perf_ld_stall <= perf_ld_stall + 32'd1;
      if (if_id_flush && !(&perf_flush)) perf_flush <= perf_flush + 32'd1;
      if (mem_busy && !(&perf_freeze)) perf_freeze <= perf_freeze + 32'd1;
    end
`endif
endmodule
